surf_dac_loader: RTL and testbench

- Owns the 32-entry trim/threshold DAC value store on the SURF.
- Accepts single-word writes from the local-bus front end (dac_wr/dac_waddr/dac_dat) and gives combinational readback for housekeeping (dac_raddr/dac_dat).
- On an update request, serially loads all 32 values into four 8-channel serial DACs and reports busy while doing so.
- Sits directly downstream of the bus interface block: it consumes that block's dac_* outputs and drives its dac_busy_i input.

---
 rtl/surf_dac_loader_pkg.sv | 26 ++
 rtl/surf_dac_loader_if.sv | 25 ++
 rtl/surf_dac_loader_spi_shifter.sv | 84 ++++++++
 rtl/surf_dac_loader.sv | 122 ++++++++++++
 tb/tb_surf_dac_loader.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/surf_dac_loader_pkg.sv
`default_nettype none
// ============================================================================
// surf_dac_pkg : frame constants, FSM encoding and frame builder for surf_dac_loader
// Revision 1.0
// ============================================================================
package surf_dac_pkg;

  localparam logic [3:0] CMD_WR_UPD = 4'h3;
  localparam int         FRAME_BITS = 24;
  localparam int         NUM_CH     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // 24-bit DAC word: command nibble, reserved bit, local channel, value.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [2:0]  lch,
                                                       input logic [15:0] data);
    return {CMD_WR_UPD, 1'b0, lch, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/surf_dac_loader_if.sv
`default_nettype none
// ============================================================================
// surf_dac_loader_if : local-bus side of the DAC value store (write, readback, update)
// Revision 1.0
// ============================================================================
interface surf_dac_loader_if;
  import surf_dac_pkg::*;

  localparam int AW = $clog2(NUM_CH);

  logic          wr_i;
  logic [AW-1:0] waddr_i;
  logic [15:0]   dat_i;
  logic [AW-1:0] raddr_i;
  logic [15:0]   dat_o;
  logic          update_i;
  logic          busy_o;

  modport master (output wr_i, waddr_i, dat_i, raddr_i, update_i,
                  input  dat_o, busy_o);
  modport slave  (input  wr_i, waddr_i, dat_i, raddr_i, update_i,
                  output dat_o, busy_o);

endinterface
`default_nettype wire

// File: rtl/surf_dac_loader_spi_shifter.sv
`default_nettype none
// ============================================================================
// surf_dac_spi_shifter : shifts one 24-bit frame MSB first to the selected DAC chip
// Revision 1.0
// ============================================================================
module surf_dac_spi_shifter
  import surf_dac_pkg::*;
#(
  parameter int CLKDIV   = 2,
  parameter int NUM_DACS = 4
) (
  input  logic                        clk_i,
  input  logic                        nrst_i,
  input  logic                        start_i,
  input  logic [FRAME_BITS-1:0]       frame_i,
  input  logic [$clog2(NUM_DACS)-1:0] chip_i,
  output logic                        sclk_o,
  output logic                        din_o,
  output logic [NUM_DACS-1:0]         ncs_o,
  output logic                        done_o
);

  localparam int             DW       = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int             BW       = $clog2(FRAME_BITS);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLKDIV - 1);

  logic                  active_q;
  logic                  high_q;
  logic [DW-1:0]         div_q;
  logic [BW-1:0]         bit_q;
  logic [FRAME_BITS-1:0] sh_q;
  logic                  phase_end;

  assign phase_end = active_q && (div_q == DIV_LAST);
  assign done_o    = phase_end && high_q && (bit_q == '0);

  // Data advances only on the high->low phase change, so din is stable across each rising edge.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      active_q <= 1'b0;
      high_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      high_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= BW'(FRAME_BITS - 1);
      sh_q     <= frame_i;
    end else if (active_q) begin
      if (phase_end) begin
        div_q  <= '0;
        high_q <= ~high_q;
        if (high_q) begin
          if (bit_q == '0) begin
            active_q <= 1'b0;
          end else begin
            bit_q <= bit_q - 1'b1;
            sh_q  <= {sh_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  always_comb begin
    ncs_o  = '1;
    din_o  = 1'b0;
    sclk_o = 1'b0;
    if (start_i) begin
      ncs_o[chip_i] = 1'b0;
      din_o         = frame_i[FRAME_BITS-1];
    end else if (active_q) begin
      ncs_o[chip_i] = 1'b0;
      din_o         = sh_q[FRAME_BITS-1];
      sclk_o        = high_q;
    end
  end

endmodule
`default_nettype wire

// File: rtl/surf_dac_loader.sv
`default_nettype none
// ============================================================================
// surf_dac_loader : 32-entry DAC value store with sequenced serial load of all channels
// Revision 1.0
// ============================================================================
module surf_dac_loader
  import surf_dac_pkg::*;
#(
  parameter int CLKDIV     = 2,
  parameter int GAP_CYCLES = 4,
  parameter int NUM_DACS   = 4,
  parameter int CH_PER_DAC = 8
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  surf_dac_loader_if.slave    bus,
  output logic                dac_sclk_o,
  output logic                dac_din_o,
  output logic [NUM_DACS-1:0] dac_ncs_o
);

  localparam int              CHW      = $clog2(NUM_CH);
  localparam int              LCW      = $clog2(CH_PER_DAC);
  localparam int              CPW      = $clog2(NUM_DACS);
  localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [CHW-1:0]  CH_LAST  = CHW'(NUM_CH - 1);

  logic [15:0]           mem_q [NUM_CH];
  state_e                state_q, state_d;
  logic [CHW-1:0]        ch_q, ch_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  pending_q, pending_d;
  logic                  shift_done;
  logic [FRAME_BITS-1:0] frame;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int i = 0; i < NUM_CH; i++) mem_q[i] <= '0;
    end else if (bus.wr_i) begin
      mem_q[bus.waddr_i] <= bus.dat_i;
    end
  end

  assign bus.dat_o  = mem_q[bus.raddr_i];
  assign bus.busy_o = (state_q != ST_IDLE);
  // Read in LOAD and captured at that cycle's edge, so a write on the same edge misses this load.
  assign frame      = make_frame(ch_q[LCW-1:0], mem_q[ch_q]);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      gap_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    gap_d     = gap_q;
    pending_d = pending_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.update_i) begin
          state_d = ST_LOAD;
          ch_d    = '0;
        end
      end
      ST_LOAD: state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (shift_done) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (ch_q != CH_LAST) begin
            ch_d    = ch_q + 1'b1;
            state_d = ST_LOAD;
          end else if (pending_q || bus.update_i) begin
            ch_d    = '0;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && bus.update_i) pending_d = 1'b1;
    // The final gap exit either consumes the request (restart) or finds none.
    if ((state_q == ST_GAP) && (gap_q == GAP_LAST) && (ch_q == CH_LAST)) pending_d = 1'b0;
  end

  surf_dac_spi_shifter #(
    .CLKDIV   (CLKDIV),
    .NUM_DACS (NUM_DACS)
  ) u_shifter (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .start_i (state_q == ST_LOAD),
    .frame_i (frame),
    .chip_i  (ch_q[LCW +: CPW]),
    .sclk_o  (dac_sclk_o),
    .din_o   (dac_din_o),
    .ncs_o   (dac_ncs_o),
    .done_o  (shift_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_surf_dac_loader.sv
`default_nettype none
// ============================================================================
// tb_surf_dac_loader : table vectors, directed load sequences and randomized traffic
// Revision 1.0
// ============================================================================
module tb_surf_dac_loader;

  localparam int FRAME_CYC = 1 + 48 * 2 + 4;
  localparam int LOAD_CYC  = 32 * FRAME_CYC;

  typedef struct {
    int          idx;
    logic [1:0]  chip;
    logic [1:0]  exp_chip;
    logic [23:0] got;
    logic [23:0] exp;
    int          nb;
  } frame_t;

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic [4:0]  ra;
    logic [15:0] exp;
  } vec_t;

  logic       clk  = 1'b0;
  logic       nrst = 1'b0;
  logic       sclk, din;
  logic [3:0] ncs;

  surf_dac_loader_if bus();

  surf_dac_loader #(
    .CLKDIV     (2),
    .GAP_CYCLES (4),
    .NUM_DACS   (4),
    .CH_PER_DAC (8)
  ) dut (
    .clk_i      (clk),
    .nrst_i     (nrst),
    .bus        (bus),
    .dac_sclk_o (sclk),
    .dac_din_o  (din),
    .dac_ncs_o  (ncs)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference store: a write issued in one cycle is visible from the next edge on.
  logic [15:0] ref_mem [32];
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 32; i++) ref_mem[i] <= '0;
    end else if (bus.wr_i) begin
      ref_mem[bus.waddr_i] <= bus.dat_i;
    end
  end

  // SPI slave: frames arrive for channels 0..31 in order; the expected value is the
  // store contents seen when the chip's nCS first drops.
  frame_t frames[$];
  frame_t cur;
  int     mon_idx   = 0;
  int     multi_low = 0;
  int     sclk_err  = 0;
  logic   in_fr     = 1'b0;
  logic   prev_sclk = 1'b0;

  always @(negedge clk) begin
    int         nlow;
    int         lo;
    logic [4:0] ec;
    if (!nrst) begin
      in_fr     = 1'b0;
      mon_idx   = 0;
      prev_sclk = 1'b0;
    end else begin
      nlow = 0;
      lo   = 0;
      for (int i = 0; i < 4; i++) if (!ncs[i]) begin nlow++; lo = i; end
      if (nlow > 1) multi_low++;
      if (nlow == 0 && sclk) sclk_err++;
      if (!in_fr && nlow == 1) begin
        in_fr        = 1'b1;
        ec           = 5'(mon_idx % 32);
        cur.idx      = mon_idx;
        cur.chip     = 2'(lo);
        cur.exp_chip = ec[4:3];
        cur.exp      = {4'h3, 1'b0, ec[2:0], ref_mem[ec]};
        cur.got      = '0;
        cur.nb       = 0;
        mon_idx++;
      end
      if (in_fr && sclk && !prev_sclk) begin
        cur.got = {cur.got[22:0], din};
        cur.nb++;
      end
      if (in_fr && nlow == 0) begin
        frames.push_back(cur);
        in_fr = 1'b0;
      end
      prev_sclk = sclk;
    end
  end

  frame_t cap[$];
  vec_t   vt[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    bus.wr_i    = 1'b1;
    bus.waddr_i = a;
    bus.dat_i   = d;
    step();
    bus.wr_i    = 1'b0;
  endtask

  task automatic pulse_update();
    bus.update_i = 1'b1;
    step();
    bus.update_i = 1'b0;
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (bus.busy_o && n < 20000) begin
      n++;
      step();
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20000 && bus.busy_o; k++) step();
    chk("idle_timeout", 32'(bus.busy_o), 32'd0);
  endtask

  task automatic wait_idx(input int t);
    for (int k = 0; k < 20000 && mon_idx < t; k++) step();
    chk("frame_wait_timeout", 32'(mon_idx >= t), 32'd1);
  endtask

  task automatic drain(input int n);
    frame_t f;
    cap = {};
    chk("frame_count", 32'(frames.size()), 32'(n));
    while (frames.size() > 0) begin
      f = frames.pop_front();
      cap.push_back(f);
      chk($sformatf("frame%0d_chip_data", f.idx), {6'd0, f.chip, f.got}, {6'd0, f.exp_chip, f.exp});
      chk($sformatf("frame%0d_bits", f.idx), 32'(f.nb), 32'd24);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    vt[0] = '{1'b1, 5'd5,  16'hA5C3, 5'd5,  16'h0000};
    vt[1] = '{1'b0, 5'd0,  16'h0000, 5'd5,  16'hA5C3};
    vt[2] = '{1'b0, 5'd0,  16'h0000, 5'd4,  16'h0000};
    vt[3] = '{1'b0, 5'd0,  16'h0000, 5'd6,  16'h0000};
    vt[4] = '{1'b1, 5'd31, 16'hFFFF, 5'd31, 16'h0000};
    vt[5] = '{1'b0, 5'd0,  16'h0000, 5'd31, 16'hFFFF};
    vt[6] = '{1'b1, 5'd0,  16'h1234, 5'd5,  16'hA5C3};
    vt[7] = '{1'b0, 5'd0,  16'h0000, 5'd0,  16'h1234};
    vt[8] = '{1'b1, 5'd5,  16'h0001, 5'd5,  16'hA5C3};
    vt[9] = '{1'b0, 5'd0,  16'h0000, 5'd5,  16'h0001};

    bus.wr_i = 1'b0; bus.waddr_i = '0; bus.dat_i = '0; bus.raddr_i = '0; bus.update_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    step();
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_ncs",  32'(ncs), 32'hF);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_din",  32'(din), 32'd0);

    for (int i = 0; i < 10; i++) begin
      bus.wr_i    = vt[i].wr;
      bus.waddr_i = vt[i].wa;
      bus.dat_i   = vt[i].wd;
      bus.raddr_i = vt[i].ra;
      #1;
      chk($sformatf("vec%0d_readback", i), 32'(bus.dat_o), 32'(vt[i].exp));
      step();
    end
    bus.wr_i = 1'b0;

    // Mid-sim reset clears the store and idles the lines.
    nrst = 1'b0;
    step();
    chk("rst2_busy", 32'(bus.busy_o), 32'd0);
    chk("rst2_ncs",  32'(ncs), 32'hF);
    chk("rst2_sclk", 32'(sclk), 32'd0);
    for (int a = 0; a < 32; a++) begin
      bus.raddr_i = 5'(a);
      #1;
      chk($sformatf("rst2_mem%0d", a), 32'(bus.dat_o), 32'd0);
    end
    nrst = 1'b1;
    step();

    // Full load of preloaded ramp.
    for (int a = 0; a < 32; a++) wr(5'(a), 16'h1000 + 16'(a));
    pulse_update();
    measure_busy(n);
    chk("busy_one_load", 32'(n), 32'(LOAD_CYC));
    drain(32);
    chk("ch10_frame", 32'(cap[10].got), 32'h32100A);
    chk("ch10_chip",  32'(cap[10].chip), 32'd1);
    chk("multi_ncs_low", 32'(multi_low), 32'd0);
    chk("sclk_without_ncs", 32'(sclk_err), 32'd0);

    // Two requests during a load collapse into one extra load.
    pulse_update();
    fork
      measure_busy(n);
      begin
        repeat (700) step();
        pulse_update();
        repeat (200) step();
        pulse_update();
      end
    join
    chk("busy_two_loads", 32'(n), 32'(2 * LOAD_CYC));
    drain(64);

    // Writes while ch 3 is shifting: ch 20 not yet snapshotted, ch 1 already sent.
    base = mon_idx;
    pulse_update();
    fork
      measure_busy(n);
      begin
        wait_idx(base + 4);
        repeat (10) step();
        wr(5'd20, 16'hBEEF);
        wr(5'd1,  16'h7777);
      end
    join
    chk("busy_wr_load", 32'(n), 32'(LOAD_CYC));
    drain(32);
    chk("wrbusy_ch20_new", 32'(cap[20].got[15:0]), 32'hBEEF);
    chk("wrbusy_ch1_old",  32'(cap[1].got[15:0]),  32'h1001);
    pulse_update();
    measure_busy(n);
    drain(32);
    chk("next_ch1_new",  32'(cap[1].got[15:0]),  32'h7777);
    chk("next_ch20_new", 32'(cap[20].got[15:0]), 32'hBEEF);

    // Asynchronous reset during ch 7's shift.
    base = mon_idx;
    pulse_update();
    wait_idx(base + 8);
    repeat (20) step();
    chk("pre_rst_ncs_low", 32'(ncs != 4'hF), 32'd1);
    nrst = 1'b0;
    #1;
    chk("async_rst_ncs",  32'(ncs), 32'hF);
    chk("async_rst_sclk", 32'(sclk), 32'd0);
    chk("async_rst_din",  32'(din), 32'd0);
    chk("async_rst_busy", 32'(bus.busy_o), 32'd0);
    drain(7);
    step();
    nrst = 1'b1;
    step();
    bus.raddr_i = 5'd20;
    #1;
    chk("post_rst_mem20", 32'(bus.dat_o), 32'd0);
    step();
    pulse_update();
    measure_busy(n);
    chk("busy_after_rst", 32'(n), 32'(LOAD_CYC));
    drain(32);
    chk("post_rst_ch0",  32'(cap[0].got), 32'h300000);
    chk("post_rst_ch20", {8'd0, 6'd0, cap[20].chip, cap[20].got}, {8'd0, 6'd0, 2'd2, 24'h340000});

    // Randomized writes, readbacks and update requests against the reference store.
    base = mon_idx;
    for (int c = 0; c < 8000; c++) begin
      bus.wr_i     = ($urandom_range(3) == 0);
      bus.waddr_i  = 5'($urandom);
      bus.dat_i    = 16'($urandom);
      bus.raddr_i  = 5'($urandom);
      bus.update_i = ($urandom_range(399) == 0);
      #1;
      chk("rand_readback", 32'(bus.dat_o), 32'(ref_mem[bus.raddr_i]));
      step();
    end
    bus.wr_i     = 1'b0;
    bus.update_i = 1'b0;
    wait_idle();
    n = mon_idx - base;
    chk("rand_whole_loads", 32'(n % 32), 32'd0);
    drain(n);
    chk("final_multi_ncs_low", 32'(multi_low), 32'd0);
    chk("final_sclk_without_ncs", 32'(sclk_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
